// File: rtl/mic_frame_assembler.sv
// Pairs stereo sample words from two mic receivers into 4-channel frames,
// rounds/saturates each channel to OUT_WIDTH and queues frames in a FIFO.
module mic_frame_assembler #(
    parameter int DATA_WIDTH   = 24,
    parameter int OUT_WIDTH    = 18,
    parameter int FIFO_DEPTH   = 8,
    parameter int SKEW_TIMEOUT = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           a_left,
    input  logic [DATA_WIDTH-1:0]           a_right,
    input  logic                            a_valid,
    input  logic [DATA_WIDTH-1:0]           b_left,
    input  logic [DATA_WIDTH-1:0]           b_right,
    input  logic                            b_valid,
    output logic [4*OUT_WIDTH-1:0]          m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overrun,
    output logic                            skew_err,
    input  logic                            clear_err
);

    localparam int K  = DATA_WIDTH - OUT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SKEW_TIMEOUT > 2) ? $clog2(SKEW_TIMEOUT) : 1;
    localparam int FW = 4 * OUT_WIDTH;

    localparam logic [CW-1:0]               CNT_LAST = CW'(SKEW_TIMEOUT - 1);
    localparam logic [AW:0]                 LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [DATA_WIDTH:0]  HALF     = (DATA_WIDTH+1)'(1) <<< (K - 1);
    localparam logic signed [DATA_WIDTH:0]  MAX_POS  =
        ((DATA_WIDTH+1)'(1) <<< (OUT_WIDTH - 1)) - (DATA_WIDTH+1)'(1);

    // Round half up, then clip the positive side only; the floor shift
    // can never push a negative value below the OUT_WIDTH minimum.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(
        input logic signed [DATA_WIDTH-1:0] x
    );
        logic signed [DATA_WIDTH:0] wide;
        wide = ($signed({x[DATA_WIDTH-1], x}) + HALF) >>> K;
        if (wide > MAX_POS)
            return MAX_POS[OUT_WIDTH-1:0];
        return wide[OUT_WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_A} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   held_a_left, held_a_right, held_b_left, held_b_right;
    logic                    push, use_held_a, use_held_b;
    logic                    latch_a, latch_b, cnt_clr, skew_evt, timeout;

    logic [FW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    full, push_ok, pop;
    logic [FW-1:0]           frame;
    logic [DATA_WIDTH-1:0]   src_a_left, src_a_right, src_b_left, src_b_right;

    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        use_held_a = 1'b0;
        use_held_b = 1'b0;
        latch_a    = 1'b0;
        latch_b    = 1'b0;
        cnt_clr    = 1'b0;
        skew_evt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    push = 1'b1;
                end else if (a_valid) begin
                    latch_a   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT_B;
                end else if (b_valid) begin
                    latch_b   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT_A;
                end
            end
            WAIT_B: begin
                if (b_valid) begin
                    push       = 1'b1;
                    use_held_a = 1'b1;
                    if (a_valid) begin
                        latch_a = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (a_valid) begin
                    latch_a  = 1'b1;
                    cnt_clr  = 1'b1;
                    skew_evt = 1'b1;
                end else if (timeout) begin
                    skew_evt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_A: begin
                if (a_valid) begin
                    push       = 1'b1;
                    use_held_b = 1'b1;
                    if (b_valid) begin
                        latch_b = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (b_valid) begin
                    latch_b  = 1'b1;
                    cnt_clr  = 1'b1;
                    skew_evt = 1'b1;
                end else if (timeout) begin
                    skew_evt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            held_a_left  <= '0;
            held_a_right <= '0;
            held_b_left  <= '0;
            held_b_right <= '0;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (!timeout)
                cnt <= cnt + 1'b1;
            if (latch_a) begin
                held_a_left  <= a_left;
                held_a_right <= a_right;
            end
            if (latch_b) begin
                held_b_left  <= b_left;
                held_b_right <= b_right;
            end
        end
    end

    assign src_a_left  = use_held_a ? held_a_left  : a_left;
    assign src_a_right = use_held_a ? held_a_right : a_right;
    assign src_b_left  = use_held_b ? held_b_left  : b_left;
    assign src_b_right = use_held_b ? held_b_right : b_right;

    assign frame = {round_sat(src_b_right), round_sat(src_b_left),
                    round_sat(src_a_right), round_sat(src_a_left)};

    // Fullness is taken from the registered level, so a same-cycle pop
    // cannot make room for an incoming frame.
    assign full    = (fifo_level == LVL_FULL);
    assign m_valid = (fifo_level != '0);
    assign pop     = m_valid && m_ready;
    assign push_ok = push && !full;
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= frame;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Error events take priority over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun  <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            if (push && full)
                overrun <= 1'b1;
            else if (clear_err)
                overrun <= 1'b0;
            if (skew_evt)
                skew_err <= 1'b1;
            else if (clear_err)
                skew_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mic_frame_assembler.sv
// Randomized bench for mic_frame_assembler: frames predicted from the pairing
// rules and the rounding formula, popped frames collected and compared in order.
module tb_mic_frame_assembler;

    localparam int DW = 24;
    localparam int OW = 18;
    localparam int FD = 8;
    localparam int ST = 256;
    localparam int K  = DW - OW;
    localparam int FW = 4 * OW;

    logic                  clk, rst;
    logic [DW-1:0]         a_left, a_right, b_left, b_right;
    logic                  a_valid, b_valid, m_ready, clear_err;
    logic [FW-1:0]         m_data;
    logic                  m_valid;
    logic [$clog2(FD):0]   fifo_level;
    logic                  overrun, skew_err;

    int            checks, errors, stall_bad;
    bit            rand_ready, stalled_prev;
    logic [FW-1:0] prev_data;
    logic [FW-1:0] got[$];
    logic [FW-1:0] exp_q[$];

    mic_frame_assembler #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .SKEW_TIMEOUT(ST)
    ) dut (
        .clk(clk), .rst(rst),
        .a_left(a_left), .a_right(a_right), .a_valid(a_valid),
        .b_left(b_left), .b_right(b_right), .b_valid(b_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .overrun(overrun), .skew_err(skew_err),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] conv(input logic [DW-1:0] x);
        longint v, y, maxp;
        v    = longint'($signed(x));
        maxp = (longint'(1) << (OW - 1)) - 1;
        y    = (v + (longint'(1) << (K - 1))) >>> K;
        if (y > maxp) y = maxp;
        return y[OW-1:0];
    endfunction

    function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] al, ar, bl, br);
        return {conv(br), conv(bl), conv(ar), conv(al)};
    endfunction

    function automatic logic [DW-1:0] rnd_sample();
        case ($urandom_range(0, 7))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return 24'hFFFFE0;
            default: return DW'($urandom());
        endcase
    endfunction

    // One clock: record a pop if one happens at this edge, track stall stability.
    task automatic cycle();
        logic          pre;
        logic [FW-1:0] d;
        if (stalled_prev && m_data !== prev_data) stall_bad++;
        pre          = m_valid && m_ready;
        d            = m_data;
        stalled_prev = m_valid && !m_ready;
        prev_data    = m_data;
        @(posedge clk);
        #1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        clear_err = 1'b0;
        if (pre) got.push_back(d);
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_a(input logic [DW-1:0] l, r);
        a_left = l; a_right = r; a_valid = 1'b1;
    endtask

    task automatic set_b(input logic [DW-1:0] l, r);
        b_left = l; b_right = r; b_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_m_data got %h want 0", m_data); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL rst_skew_err got %b want 0", skew_err); end
        rst = 1'b0;
        stalled_prev = 1'b0;
        got.delete();
    endtask

    task automatic test_aligned();
        logic [FW-1:0] want;
        logic [DW-1:0] al, ar, bl, br;
        want = {18'h20000, 18'h1FFFF, 18'h00000, 18'h00001};
        got.delete(); exp_q.delete();
        set_a(24'h00003F, 24'h00001F);
        set_b(24'h7FFFFF, 24'h800000);
        cycle();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL aligned_valid got %b want 1", m_valid); end
        checks++; if (m_data !== want) begin errors++; $display("FAIL aligned_data got %h want %h", m_data, want); end
        checks++; if (fifo_level !== 1) begin errors++; $display("FAIL aligned_level got %0d want 1", fifo_level); end
        exp_q.push_back(want);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            al = rnd_sample(); ar = rnd_sample(); bl = rnd_sample(); br = rnd_sample();
            set_a(al, ar); set_b(bl, br);
            exp_q.push_back(frame_of(al, ar, bl, br));
            cycle();
        end
        repeat (4) cycle();
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL aligned_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL aligned_frame%0d got %h want %h", i, (i < got.size()) ? got[i] : {FW{1'bx}}, exp_q[i]);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_skew();
        logic [DW-1:0] a1l, a1r, b1l, b1r, a3l, a3r, b3l, b3r;
        a1l = rnd_sample(); a1r = rnd_sample(); b1l = rnd_sample(); b1r = rnd_sample();
        m_ready = 1'b0;
        set_a(a1l, a1r);
        cycle();
        repeat (99) cycle();
        set_b(b1l, b1r);
        cycle();
        checks++; if (fifo_level !== 1) begin errors++; $display("FAIL skew100_level got %0d want 1", fifo_level); end
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL skew100_err got %b want 0", skew_err); end
        checks++; if (m_data !== frame_of(a1l, a1r, b1l, b1r)) begin errors++; $display("FAIL skew100_data got %h want %h", m_data, frame_of(a1l, a1r, b1l, b1r)); end
        m_ready = 1'b1; cycle(); m_ready = 1'b0;
        set_a(rnd_sample(), rnd_sample());
        cycle();
        repeat (ST - 1) cycle();
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", skew_err); end
        cycle();
        checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", skew_err); end
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL timeout_level got %0d want 0", fifo_level); end
        a3l = rnd_sample(); a3r = rnd_sample(); b3l = rnd_sample(); b3r = rnd_sample();
        set_b(b3l, b3r);
        cycle();
        set_a(a3l, a3r);
        cycle();
        checks++; if (fifo_level !== 1) begin errors++; $display("FAIL idle_probe_level got %0d want 1", fifo_level); end
        checks++; if (m_data !== frame_of(a3l, a3r, b3l, b3r)) begin errors++; $display("FAIL idle_probe_data got %h want %h", m_data, frame_of(a3l, a3r, b3l, b3r)); end
        m_ready = 1'b1; cycle(); m_ready = 1'b0;
        clear_err = 1'b1;
        cycle();
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL skew_clear got %b want 0", skew_err); end
        got.delete();
    endtask

    task automatic test_overrun();
        logic [DW-1:0] al, ar, bl, br;
        got.delete(); exp_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < FD; i++) begin
            al = rnd_sample(); ar = rnd_sample(); bl = rnd_sample(); br = rnd_sample();
            set_a(al, ar); set_b(bl, br);
            exp_q.push_back(frame_of(al, ar, bl, br));
            cycle();
        end
        checks++; if (fifo_level !== FD) begin errors++; $display("FAIL full_level got %0d want %0d", fifo_level, FD); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_no_overrun got %b want 0", overrun); end
        set_a(rnd_sample(), rnd_sample()); set_b(rnd_sample(), rnd_sample());
        cycle();
        checks++; if (fifo_level !== FD) begin errors++; $display("FAIL ovf_level got %0d want %0d", fifo_level, FD); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overrun); end
        set_a(rnd_sample(), rnd_sample()); set_b(rnd_sample(), rnd_sample());
        m_ready = 1'b1; clear_err = 1'b1;
        cycle();
        checks++; if (fifo_level !== FD - 1) begin errors++; $display("FAIL ovf_pop_level got %0d want %0d", fifo_level, FD - 1); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovf_clear_race got %b want 1", overrun); end
        m_ready = 1'b0; clear_err = 1'b1;
        cycle();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overrun); end
        m_ready = 1'b1;
        repeat (FD + 4) cycle();
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL drain_level got %0d want 0", fifo_level); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", m_valid); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_frame%0d got %h want %h", i, (i < got.size()) ? got[i] : {FW{1'bx}}, exp_q[i]);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] al, ar, bl, br;
        int            pat, gap, guard;
        got.delete(); exp_q.delete();
        stall_bad = 0;
        rand_ready = 1'b1;
        m_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            pat = $urandom_range(0, 2);
            gap = $urandom_range(0, 20);
            al = rnd_sample(); ar = rnd_sample(); bl = rnd_sample(); br = rnd_sample();
            if (pat == 1) begin
                set_a(al, ar); cycle(); repeat (gap) cycle();
            end else if (pat == 2) begin
                set_b(bl, br); cycle(); repeat (gap) cycle();
            end
            guard = 0;
            while (exp_q.size() - got.size() >= FD && guard < 50) begin
                m_ready = 1'b1;
                cycle();
                guard++;
            end
            if (pat != 1) set_a(al, ar);
            if (pat != 2) set_b(bl, br);
            exp_q.push_back(frame_of(al, ar, bl, br));
            cycle();
            repeat ($urandom_range(0, 2)) cycle();
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        repeat (20) cycle();
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_frame%0d got %h want %h", i, (i < got.size()) ? got[i] : {FW{1'bx}}, exp_q[i]);
            end
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun got %b want 0", overrun); end
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL bp_skew_err got %b want 0", skew_err); end
        m_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] al, ar, bl, br;
        got.delete(); exp_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) m_ready = 1'b1;
            al = rnd_sample(); ar = rnd_sample(); bl = rnd_sample(); br = rnd_sample();
            set_a(al, ar); set_b(bl, br);
            exp_q.push_back(frame_of(al, ar, bl, br));
            cycle();
            if (i >= 3) begin
                checks++;
                if (fifo_level !== 3) begin errors++; $display("FAIL wrap_level%0d got %0d want 3", i, fifo_level); end
            end
        end
        repeat (6) cycle();
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_frame%0d got %h want %h", i, (i < got.size()) ? got[i] : {FW{1'bx}}, exp_q[i]);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] bl, br, al, ar;
        got.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_a(rnd_sample(), rnd_sample()); set_b(rnd_sample(), rnd_sample());
            cycle();
        end
        set_a(rnd_sample(), rnd_sample());
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", m_valid); end
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", m_data); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        stalled_prev = 1'b0;
        m_ready = 1'b1;
        bl = rnd_sample(); br = rnd_sample(); al = rnd_sample(); ar = rnd_sample();
        set_b(bl, br);
        cycle();
        repeat (5) cycle();
        checks++; if (got.size() != 0) begin errors++; $display("FAIL midrst_stale got %0d frames want 0", got.size()); end
        set_a(al, ar);
        cycle();
        repeat (3) cycle();
        checks++;
        if (got.size() != 1 || got[0] !== frame_of(al, ar, bl, br)) begin
            errors++;
            $display("FAIL midrst_pair got %0d frames first %h want 1 frame %h", got.size(), (got.size() > 0) ? got[0] : {FW{1'bx}}, frame_of(al, ar, bl, br));
        end
        m_ready = 1'b0;
    endtask

    task automatic test_clear_err();
        logic [DW-1:0] al, ar, bl, br;
        got.delete();
        m_ready = 1'b0;
        set_a(rnd_sample(), rnd_sample());
        cycle();
        set_a(rnd_sample(), rnd_sample());
        cycle();
        checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL double_a_err got %b want 1", skew_err); end
        al = rnd_sample(); ar = rnd_sample(); bl = rnd_sample(); br = rnd_sample();
        set_a(al, ar);
        clear_err = 1'b1;
        cycle();
        checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL clear_race got %b want 1", skew_err); end
        clear_err = 1'b1;
        cycle();
        checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL clear_only got %b want 0", skew_err); end
        set_b(bl, br);
        cycle();
        m_ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (got.size() != 1 || got[0] !== frame_of(al, ar, bl, br)) begin
            errors++;
            $display("FAIL clear_pair got %0d frames first %h want 1 frame %h", got.size(), (got.size() > 0) ? got[0] : {FW{1'bx}}, frame_of(al, ar, bl, br));
        end
        m_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; stall_bad = 0;
        rand_ready = 1'b0; stalled_prev = 1'b0; prev_data = '0;
        rst = 1'b1;
        a_left = '0; a_right = '0; b_left = '0; b_right = '0;
        a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b0; clear_err = 1'b0;
        test_reset();
        test_aligned();
        test_skew();
        test_overrun();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_clear_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
